// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: port ids, arbiter states, read-return tag.
package dmem_arb_pkg;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_LDR = 1'b1
  } port_id_t;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic     valid;
    port_id_t port;
  } rd_tag_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the data_mem side of the arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_lock;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  // Requesters and the memory, seen from outside the arbiter.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output mem_dout,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_din
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  mem_dout,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: on a tie the port that did not win last time wins.
// Latency: purely combinational.
// Backpressure: none; a non-requesting port is never granted.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last_winner,
  output logic [1:0] gnt,
  output port_id_t   winner
);

  always_comb begin
    gnt    = 2'b00;
    winner = last_winner;
    if (req == 2'b11) begin
      winner = (last_winner == PORT_CPU) ? PORT_LDR : PORT_CPU;
      gnt    = (winner == PORT_LDR) ? 2'b10 : 2'b01;
    end else if (req[0]) begin
      winner = PORT_CPU;
      gnt    = 2'b01;
    end else if (req[1]) begin
      winner = PORT_LDR;
      gnt    = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-ported data_mem between CPU LSU (port 0) and loader/debug (port 1), with port-1 burst lock.
// Latency: grant and mem issue combinational from req; read data returns one cycle after grant.
// Backpressure: a request is held until its gnt; port 1 locks for at most LOCK_MAX grants while port 0 waits.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  arb_state_t        state, state_nxt;
  logic [CNT_W-1:0]  lock_cnt, lock_cnt_nxt;
  port_id_t          last_winner, rr_winner, winner;
  logic [1:0]        rr_gnt, gnt;
  rd_tag_t           rtag;
  logic              issue_en, issue_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  rr_arb2 u_rr (
    .req         ({bus.m1_req, bus.m0_req}),
    .last_winner (last_winner),
    .gnt         (rr_gnt),
    .winner      (rr_winner)
  );

  always_comb begin
    gnt          = rr_gnt;
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    case (state)
      ARB_OPEN: begin
        if (rr_gnt[1] && bus.m1_lock) begin
          state_nxt    = ARB_LOCKED;
          lock_cnt_nxt = CNT_W'(1);
        end
      end
      ARB_LOCKED: begin
        if (bus.m1_req && bus.m1_lock) begin
          // Past LOCK_MAX port 1 keeps going only while port 0 is idle; the count saturates.
          if ((lock_cnt < CNT_MAX) || !bus.m0_req) begin
            gnt = 2'b10;
            if (lock_cnt < CNT_MAX) lock_cnt_nxt = lock_cnt + CNT_W'(1);
          end else begin
            gnt          = 2'b01;
            state_nxt    = ARB_OPEN;
            lock_cnt_nxt = '0;
          end
        end else begin
          // Lock released or port 1 idle: plain round-robin decides this cycle.
          state_nxt    = ARB_OPEN;
          lock_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = ARB_OPEN;
        lock_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    winner    = gnt[1] ? PORT_LDR : (gnt[0] ? PORT_CPU : rr_winner);
    issue_en  = |gnt;
    issue_we  = 1'b0;
    win_addr  = bus.m0_addr;
    win_wdata = bus.m0_wdata;
    if (gnt[1]) begin
      issue_we  = bus.m1_we;
      win_addr  = bus.m1_addr;
      win_wdata = bus.m1_wdata;
    end else if (gnt[0]) begin
      issue_we  = bus.m0_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_OPEN;
      lock_cnt    <= '0;
      last_winner <= PORT_LDR;
      rtag        <= '{valid: 1'b0, port: PORT_CPU};
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      if (issue_en) last_winner <= winner;
      rtag <= '{valid: issue_en && !issue_we, port: winner};
    end
  end

  assign bus.m0_gnt    = gnt[0];
  assign bus.m1_gnt    = gnt[1];
  assign bus.mem_en    = issue_en;
  assign bus.mem_we    = issue_we;
  assign bus.mem_addr  = win_addr;
  assign bus.mem_din   = win_wdata;

  assign bus.m0_rvalid = rtag.valid && (rtag.port == PORT_CPU);
  assign bus.m1_rvalid = rtag.valid && (rtag.port == PORT_LDR);
  assign bus.m0_rdata  = bus.m0_rvalid ? bus.mem_dout : '0;
  assign bus.m1_rdata  = bus.m1_rvalid ? bus.mem_dout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous data_mem model.
module tb_dmem_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 | i;
    mem[12'h010] = 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[11:0]] <= bus.mem_din;
      else            bus.mem_dout <= mem[bus.mem_addr[11:0]];
    end
  end

  task automatic idle_ports();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.m1_lock = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] outs;
    idle_ports();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    outs = {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.mem_en, bus.mem_we};
    checks++;
    if (outs !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=%b", outs, 6'b0);
    end
    checks++;
    if (bus.m0_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_m0_rdata got=%h exp=%h", bus.m0_rdata, 32'h0);
    end
    checks++;
    if (bus.m1_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_m1_rdata got=%h exp=%h", bus.m1_rdata, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Both ports read every cycle from reset: grants go 0,1,0,1,... and data follows one cycle later.
  task automatic test_alternate();
    int i0, i1, p, idx;
    logic [31:0] exp_addr;
    i0 = 0; i1 = 0;
    for (int c = 0; c < 6; c++) begin
      bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h100 + i0;
      bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h200 + i1; bus.m1_lock = 1'b0;
      #1;
      checks++;
      if ({bus.m1_gnt, bus.m0_gnt} !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL alt_gnt cyc=%0d got=%b exp=%b", c, {bus.m1_gnt, bus.m0_gnt},
                 (c % 2 == 0) ? 2'b01 : 2'b10);
      end
      if (c > 0) begin
        p = (c - 1) % 2;
        idx = (c - 1) / 2;
        exp_addr = (p == 1) ? 32'h200 + idx : 32'h100 + idx;
        checks++;
        if ({bus.m1_rvalid, bus.m0_rvalid} !== ((p == 1) ? 2'b10 : 2'b01)) begin
          failures++;
          $display("FAIL alt_rvalid cyc=%0d got=%b exp=%b", c, {bus.m1_rvalid, bus.m0_rvalid},
                   (p == 1) ? 2'b10 : 2'b01);
        end
        checks++;
        if (((p == 1) ? bus.m1_rdata : bus.m0_rdata) !== (32'hA000_0000 | exp_addr)) begin
          failures++;
          $display("FAIL alt_rdata cyc=%0d got=%h exp=%h", c,
                   (p == 1) ? bus.m1_rdata : bus.m0_rdata, 32'hA000_0000 | exp_addr);
        end
      end
      if (bus.m0_gnt) i0++;
      if (bus.m1_gnt) i1++;
      @(negedge clk);
    end
    idle_ports();
    #1;
    checks++;
    if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== 32'hA000_0202) begin
      failures++;
      $display("FAIL alt_last_read got=%b/%h exp=1/%h", bus.m1_rvalid, bus.m1_rdata, 32'hA000_0202);
    end
    @(negedge clk);
  endtask

  task automatic test_single_read();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h010;
    #1;
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.mem_en, bus.mem_we} !== 4'b1010) begin
      failures++;
      $display("FAIL single_issue got=%b exp=%b", {bus.m0_gnt, bus.m1_gnt, bus.mem_en, bus.mem_we}, 4'b1010);
    end
    checks++;
    if (bus.mem_addr !== 32'h010) begin
      failures++; $display("FAIL single_addr got=%h exp=%h", bus.mem_addr, 32'h010);
    end
    @(negedge clk);
    idle_ports();
    #1;
    checks++;
    if ({bus.m0_rvalid, bus.m1_rvalid, bus.mem_en} !== 3'b100) begin
      failures++;
      $display("FAIL single_rvalid got=%b exp=%b", {bus.m0_rvalid, bus.m1_rvalid, bus.mem_en}, 3'b100);
    end
    checks++;
    if (bus.m0_rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL single_rdata got=%h exp=%h", bus.m0_rdata, 32'hDEAD_BEEF);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.m0_rvalid !== 1'b0) begin
      failures++; $display("FAIL single_pulse got=%b exp=%b", bus.m0_rvalid, 1'b0);
    end
    @(negedge clk);
  endtask

  // Port 0 won last, so the tie goes to the port-1 write; port 0's read then sees the new data.
  task automatic test_write_then_read();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h020;
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h020; bus.m1_wdata = 32'h0000_0055;
    #1;
    checks++;
    if ({bus.m1_gnt, bus.m0_gnt, bus.mem_we} !== 3'b101) begin
      failures++; $display("FAIL wr_issue got=%b exp=%b", {bus.m1_gnt, bus.m0_gnt, bus.mem_we}, 3'b101);
    end
    checks++;
    if (bus.mem_din !== 32'h0000_0055 || bus.mem_addr !== 32'h020) begin
      failures++;
      $display("FAIL wr_bus got=%h@%h exp=%h@%h", bus.mem_din, bus.mem_addr, 32'h55, 32'h020);
    end
    @(negedge clk);
    bus.m1_req = 1'b0; bus.m1_we = 1'b0;
    #1;
    checks++;
    if ({bus.m0_gnt, bus.m0_rvalid, bus.m1_rvalid} !== 3'b100) begin
      failures++;
      $display("FAIL rd_after_wr got=%b exp=%b", {bus.m0_gnt, bus.m0_rvalid, bus.m1_rvalid}, 3'b100);
    end
    @(negedge clk);
    idle_ports();
    #1;
    checks++;
    if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 32'h0000_0055) begin
      failures++;
      $display("FAIL rd_after_wr_data got=%b/%h exp=1/%h", bus.m0_rvalid, bus.m0_rdata, 32'h55);
    end
    @(negedge clk);
  endtask

  // Port 1 bursts 20 locked reads; port 0 wants two accesses.
  // Expected winners: c0..15 port 1 (16 grants), c16 port 0 (forced yield), c17..20 port 1, c21 port 0.
  task automatic test_lock_burst();
    int m1_left, m0_left;
    logic exp1;
    m1_left = 20; m0_left = 2;
    for (int c = 0; c < 22; c++) begin
      bus.m1_req = (m1_left > 0); bus.m1_we = 1'b0; bus.m1_lock = 1'b1; bus.m1_addr = 32'h300 + c;
      bus.m0_req = (c >= 1) && (m0_left > 0); bus.m0_we = 1'b0; bus.m0_addr = 32'h040;
      #1;
      exp1 = (c != 16) && (c != 21);
      checks++;
      if ({bus.m1_gnt, bus.m0_gnt} !== {exp1, ~exp1}) begin
        failures++;
        $display("FAIL lock_burst cyc=%0d got=%b exp=%b", c, {bus.m1_gnt, bus.m0_gnt}, {exp1, ~exp1});
      end
      if (bus.m1_gnt) m1_left--;
      if (bus.m0_gnt) m0_left--;
      @(negedge clk);
    end
    checks++;
    if (m1_left != 0 || m0_left != 0) begin
      failures++; $display("FAIL lock_burst_left got=%0d/%0d exp=0/0", m1_left, m0_left);
    end
    idle_ports();
    @(negedge clk);
  endtask

  // Locked port 1 alone past LOCK_MAX keeps winning; a late port-0 request still forces a yield.
  // Then a fresh lock is dropped with m1_lock=0 and port 0 wins that same cycle.
  task automatic test_lock_saturate_release();
    logic exp1, exp0;
    for (int c = 0; c < 21; c++) begin
      bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h400 + c;
      bus.m1_lock = (c != 20);
      bus.m0_req = (c == 18) || (c == 20); bus.m0_we = 1'b0; bus.m0_addr = 32'h050;
      #1;
      exp1 = (c < 18) || (c == 19);
      exp0 = (c == 18) || (c == 20);
      checks++;
      if ({bus.m1_gnt, bus.m0_gnt} !== {exp1, exp0}) begin
        failures++;
        $display("FAIL lock_sat cyc=%0d got=%b exp=%b", c, {bus.m1_gnt, bus.m0_gnt}, {exp1, exp0});
      end
      @(negedge clk);
    end
    idle_ports();
    @(negedge clk);
  endtask

  // Port 0 wins a read, then reset hits before the data returns.
  task automatic test_reset_midop();
    logic [5:0] outs;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h010;
    #1;
    checks++;
    if (bus.m0_gnt !== 1'b1) begin
      failures++; $display("FAIL rst_pre_gnt got=%b exp=%b", bus.m0_gnt, 1'b1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle_ports();
    @(negedge clk);
    #1;
    outs = {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.mem_en, bus.mem_we};
    checks++;
    if (outs !== 6'b0 || bus.m0_rdata !== 32'h0) begin
      failures++; $display("FAIL rst_mid_outs got=%b/%h exp=%b/%h", outs, bus.m0_rdata, 6'b0, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b00) begin
      failures++; $display("FAIL rst_no_rvalid got=%b exp=%b", {bus.m0_rvalid, bus.m1_rvalid}, 2'b00);
    end
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_addr = 32'h011;
    bus.m1_req = 1'b1; bus.m1_addr = 32'h012;
    #1;
    checks++;
    if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01) begin
      failures++; $display("FAIL rst_first_tie got=%b exp=%b", {bus.m1_gnt, bus.m0_gnt}, 2'b01);
    end
    @(negedge clk);
    idle_ports();
    #1;
    checks++;
    if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 32'hA000_0011) begin
      failures++;
      $display("FAIL rst_first_read got=%b/%h exp=1/%h", bus.m0_rvalid, bus.m0_rdata, 32'hA000_0011);
    end
    @(negedge clk);
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    checks = 0;
    failures = 0;
    idle_ports();
    test_reset();
    test_alternate();
    test_single_read();
    test_write_then_read();
    test_lock_burst();
    test_lock_saturate_release();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported synchronous data memory between the CPU load/store unit (port 0) and the program loader/debug port (port 1). Sits directly in front of `data_mem`, driving its `en`/`we`/`addr`/`din` and routing `dout` back to the requester that issued each read. Uses round-robin fairness, with a bounded lock so port 1 can perform back-to-back bursts.

## Interface
- `ADDR_W`, 32: address width passed through to memory. Memory decodes `addr[11:0]`.
- `DATA_W`, 32: data width.
- `LOCK_MAX`, 16: maximum consecutive locked grants to port 1 before a forced yield.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `m0_req` / `m1_req` in 1: access request; held with fields stable until granted.
- `m0_we` / `m1_we` in 1: 1 = write, 0 = read.
- `m0_addr` / `m1_addr` in ADDR_W: word address.
- `m0_wdata` / `m1_wdata` in DATA_W: write data.
- `m1_lock` in 1: port 1 requests to keep the grant across consecutive requests.
- `m0_gnt` / `m1_gnt` out 1: combinational; request accepted this cycle.
- `m0_rvalid` / `m1_rvalid` out 1: read data valid for this port.
- `m0_rdata` / `m1_rdata` out DATA_W: read data. Valid only while the matching `rvalid` is high.
- `mem_en`, `mem_we` out 1: to `data_mem` `en`/`we`.
- `mem_addr` out ADDR_W, `mem_din` out DATA_W: to `data_mem`.
- `mem_dout` in DATA_W: from `data_mem`; valid the cycle after a read is issued.

## Operation
- **OPEN state.** Round-robin between the ports.
  - Only one port requesting: that port wins.
  - Both requesting: the port that did not win most recently wins.
  - After reset, `last_winner` = 1, so port 0 wins the first tie.
- **Issue.** The winner's fields drive `mem_*` combinationally in the same cycle.
  - `mem_en` = 1 and the winner's `gnt` = 1.
  - With no request: `mem_en` = 0, `mem_we` = 0, address and data are don't-care.
- **Read return.** A registered tag (valid bit plus port id) captures each issued read.
  - Next cycle: the tagged port's `rvalid` = 1 and its `rdata` = `mem_dout`.
  - Writes produce no `rvalid`.
- **Throughput.** One access per cycle; read and write issues may be back-to-back.
- **Lock.**
  - OPEN→LOCKED when port 1 is granted with `m1_lock` = 1. `lock_cnt` ← 1.
  - In LOCKED, port 1 wins whenever `m1_req` = 1 and `lock_cnt` < `LOCK_MAX`; `lock_cnt` increments per grant.
  - LOCKED→OPEN when any of the following holds:
    - `m1_lock` = 0.
    - `m1_req` = 0 for a cycle; port 0 may win that same cycle.
    - `lock_cnt` = `LOCK_MAX` with `m0_req` = 1. Port 0 is granted that cycle (forced yield), and `lock_cnt` resets.
  - `lock_cnt` = `LOCK_MAX` with `m0_req` = 0: port 1 continues, and `lock_cnt` saturates.
- `last_winner` updates on every grant, including locked ones.

## Timing
- Reset values: all `gnt`, `rvalid`, `mem_en` and `mem_we` = 0; `rdata` = 0; state = OPEN; `lock_cnt` = 0; `last_winner` = 1; read tag invalid.
- Grant latency: 0 cycles, combinational from `req`. Read latency: 1 cycle from grant to `rvalid`.
- `rvalid` is a single-cycle pulse per read. A requester must not assume `gnt` in a cycle where it does not request.
- Reset asserted mid-operation: an in-flight read tag is cleared, so no `rvalid` follows. A write issued in the reset cycle is not guaranteed.
- There are no combinational paths from `mem_dout` to any `gnt`.

## Structure
- Package `dmem_arb_pkg`:
  - `port_id_t` (`PORT_CPU`=0, `PORT_LDR`=1).
  - `arb_state_t` (`ARB_OPEN`, `ARB_LOCKED`).
  - Read-tag struct {valid, `port_id_t`}.
- Sub-module `rr_arb2`: combinational two-input round-robin picker. Inputs are `req[1:0]` and `last_winner`; outputs are `gnt[1:0]` and `winner`.
- The top level holds the FSM, `lock_cnt`, read tag and `mem_*` muxing.

## Test plan
- Single read, port 0, address 0x010 (memory holds 0xDEADBEEF): `m0_gnt` is 1 in cycle N; `m0_rvalid` is 1 with 0xDEADBEEF in N+1; `m1_rvalid` stays 0.
- Both ports request reads continuously from reset: grants alternate 0,1,0,1 and `rvalid`s follow one cycle later on matching ports.
- Port 1 writes 0x00000055 to 0x020 while port 0 waits, then port 0 reads 0x020: port 0 receives 0x00000055 one cycle after its grant.
- Port 1 locked burst of 20 with `m0_req` held high and `LOCK_MAX`=16: port 1 gets 16 grants, then port 0 gets 1, then port 1 re-locks.
- `rst_n` pulsed low in the cycle after a port-0 read grant: no `rvalid`, all outputs 0, and the first post-reset tie goes to port 0.
